// File: rtl/tl_pkg.sv
// Shared definitions for the intersection phase controller.
//   tl_state_e  : 3-bit phase encoding, also driven on the phase output
//   LAMP_*      : {R,Y,G} lamp patterns for one road
//   next_phase  : successor of a phase in the normal sequence
package tl_pkg;

    typedef enum logic [2:0] {
        AR_TO_NS = 3'd0,
        NS_G     = 3'd1,
        NS_Y     = 3'd2,
        AR_TO_EW = 3'd3,
        EW_G     = 3'd4,
        EW_Y     = 3'd5,
        FLASH    = 3'd6
    } tl_state_e;

    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // FLASH is never left through this function; it always exits to AR_TO_NS.
    function automatic tl_state_e next_phase(input tl_state_e s);
        case (s)
            AR_TO_NS: next_phase = NS_G;
            NS_G:     next_phase = NS_Y;
            NS_Y:     next_phase = AR_TO_EW;
            AR_TO_EW: next_phase = EW_G;
            EW_G:     next_phase = EW_Y;
            default:  next_phase = AR_TO_NS;
        endcase
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_CYCLES clocks.
//   clk  : system clock
//   rst  : synchronous active-high reset, counter to 0
//   clr  : restart the count at 0 on the next edge (phase entry)
//   run  : advance the count
//   tick : high while the count sits at TICK_CYCLES-1
module tick_gen #(
    parameter int unsigned TICK_CYCLES = 50_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);

    // A one-cycle tick still needs a 1-bit counter to keep the vector legal.
    localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;

    assign tick = run && (count_q == LAST);

    // clr wins over the wrap so a new phase always starts a full tick period.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (run) begin
            count_d = tick ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase sequencer with pedestrian shortening and a
// flashing-yellow fallback when disabled.
//   clk, rst    : clock and synchronous active-high reset
//   en          : 1 = normal sequencing, 0 = flashing yellow
//   ped_req     : pedestrian request, latched until the next yellow
//   ns_light    : north-south {R,Y,G}
//   ew_light    : east-west {R,Y,G}
//   phase       : current phase (tl_state_e encoding)
//   rem_ticks   : ticks remaining in the phase, minus one
//   phase_start : one-cycle pulse on the first cycle of every phase
module traffic_phase_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 50_000,
    parameter int unsigned GREEN_T     = 25_000,
    parameter int unsigned YELLOW_T    = 3_000,
    parameter int unsigned ALLRED_T    = 1_000,
    parameter int unsigned PED_GREEN   = 5_000,
    parameter int unsigned FLASH_T     = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        ped_req,
    output logic [2:0]  ns_light,
    output logic [2:0]  ew_light,
    output logic [2:0]  phase,
    output logic [15:0] rem_ticks,
    output logic        phase_start
);

    localparam logic [15:0] PED_CAP = 16'(PED_GREEN - 1);

    tl_state_e   state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic        blink_q, blink_d;
    logic        ped_q, ped_d;
    logic [2:0]  ns_q, ns_d, ew_q, ew_d;
    logic        phase_start_q;
    logic        entry_d;
    logic        tick;
    logic        ped_eff;
    logic [15:0] rem_dec;

    // Countdown load value for a phase: its duration minus one.
    function automatic logic [15:0] phase_load(input tl_state_e s);
        case (s)
            NS_G, EW_G: phase_load = 16'(GREEN_T - 1);
            NS_Y, EW_Y: phase_load = 16'(YELLOW_T - 1);
            FLASH:      phase_load = 16'(FLASH_T - 1);
            default:    phase_load = 16'(ALLRED_T - 1);
        endcase
    endfunction

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (entry_d),
        .run (1'b1),
        .tick(tick)
    );

    // A request arriving in the tick cycle itself still shortens the green.
    assign ped_eff = ped_q | ped_req;
    assign rem_dec = rem_q - 16'd1;

    // Phase sequencing. Disabling always wins over an expiring phase; in
    // FLASH the countdown paces the blink instead of advancing the phase.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        blink_d = blink_q;
        ped_d   = ped_eff;
        entry_d = 1'b0;
        if (!en) begin
            if (state_q != FLASH) begin
                state_d = FLASH;
                rem_d   = phase_load(FLASH);
                blink_d = 1'b1;
                entry_d = 1'b1;
            end else if (tick) begin
                if (rem_q == 16'd0) begin
                    blink_d = ~blink_q;
                    rem_d   = phase_load(FLASH);
                end else begin
                    rem_d = rem_dec;
                end
            end
        end else if (state_q == FLASH) begin
            state_d = AR_TO_NS;
            rem_d   = phase_load(AR_TO_NS);
            entry_d = 1'b1;
        end else if (tick) begin
            if (rem_q == 16'd0) begin
                state_d = next_phase(state_q);
                rem_d   = phase_load(next_phase(state_q));
                entry_d = 1'b1;
                if (state_d == NS_Y || state_d == EW_Y) begin
                    ped_d = 1'b0;
                end
            end else begin
                rem_d = rem_dec;
                if ((state_q == NS_G || state_q == EW_G) && ped_eff && rem_dec > PED_CAP) begin
                    rem_d = PED_CAP;
                end
            end
        end
    end

    // Lamps are decoded from the next state so they change on the same edge
    // as the phase itself.
    always_comb begin
        ns_d = LAMP_R;
        ew_d = LAMP_R;
        case (state_d)
            NS_G: ns_d = LAMP_G;
            NS_Y: ns_d = LAMP_Y;
            EW_G: ew_d = LAMP_G;
            EW_Y: ew_d = LAMP_Y;
            FLASH: begin
                ns_d = blink_d ? LAMP_Y : LAMP_OFF;
                ew_d = blink_d ? LAMP_Y : LAMP_OFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= AR_TO_NS;
            rem_q         <= 16'(ALLRED_T - 1);
            blink_q       <= 1'b0;
            ped_q         <= 1'b0;
            ns_q          <= LAMP_R;
            ew_q          <= LAMP_R;
            phase_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            blink_q       <= blink_d;
            ped_q         <= ped_d;
            ns_q          <= ns_d;
            ew_q          <= ew_d;
            phase_start_q <= entry_d;
        end
    end

    assign ns_light    = ns_q;
    assign ew_light    = ew_q;
    assign phase       = state_q;
    assign rem_ticks   = rem_q;
    assign phase_start = phase_start_q;

endmodule
